irq_dispatch: RTL and testbench

Interrupt dispatcher for the NoC interface, sitting directly downstream of the IP-core status register. It watches the status block's active-low interrupt request and presents a level interrupt with a latched flag snapshot to the host/master. It then runs an acknowledge handshake with timeout and retry. Host clear/mask writes are turned into the single-cycle `en_clear` strobe plus the `clear`/`mask` vectors that drive the status register.

---
 rtl/irq_dispatch_if.sv | 29 ++
 rtl/irq_dispatch.sv | 153 +++++++++++++++
 tb/tb_irq_dispatch.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_dispatch_if.sv
// Signal bundle between the status register, the interrupt dispatcher and the host.
// slave is the dispatcher's view; master is the status-register/host side.
interface irq_dispatch_if #(
  parameter int SIZE_REG   = 'd32,
  parameter int STAT_WIDTH = 'd16
);
  logic                  int_req;
  logic [SIZE_REG-1:0]   data_status;
  logic                  cfg_wr;
  logic [SIZE_REG-1:0]   cfg_data;
  logic                  irq_ack;
  logic                  irq;
  logic [7:0]            irq_flags;
  logic                  en_clear;
  logic [STAT_WIDTH-1:0] clear;
  logic [STAT_WIDTH-1:0] mask;
  logic [1:0]            retry_cnt;
  logic                  irq_lost;

  modport slave (
    input  int_req, data_status, cfg_wr, cfg_data, irq_ack,
    output irq, irq_flags, en_clear, clear, mask, retry_cnt, irq_lost
  );

  modport master (
    output int_req, data_status, cfg_wr, cfg_data, irq_ack,
    input  irq, irq_flags, en_clear, clear, mask, retry_cnt, irq_lost
  );
endinterface

// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: turns the status block's active-low request into a level irq
// with flag snapshot, ack handshake, timeout/retry, and host clear/mask strobes.
//
// state      | meaning
// IDLE       | waiting for int_req low
// ASSERT     | irq high, timeout running, waiting for ack
// REARM      | irq low for one cycle before a retry
// WAIT_CLEAR | acked, waiting for the host clear write
// HOLDOFF    | ignoring stale int_req while the clear propagates
module irq_dispatch #(
  parameter int SIZE_REG   = 'd32,
  parameter int STAT_WIDTH = 'd16,
  parameter int TIMEOUT    = 'd1024,
  parameter int MAX_RETRY  = 'd3,
  parameter int HOLDOFF    = 'd4
) (
  input  logic            clk,
  input  logic            rst_a,
  irq_dispatch_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_REARM,
    S_WAIT_CLEAR,
    S_HOLDOFF
  } state_t;

  localparam logic [15:0] TMR_LOAD  = 16'(TIMEOUT - 1);
  localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF - 1);
  localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);

  state_t                r_state;
  logic [15:0]           r_tmr;
  logic [15:0]           r_hold;
  logic                  r_irq;
  logic [7:0]            r_flags;
  logic                  r_en_clear;
  logic [STAT_WIDTH-1:0] r_clear;
  logic [STAT_WIDTH-1:0] r_mask;
  logic [1:0]            r_retry;
  logic                  r_lost;

  logic [SIZE_REG-1:0]   w_status;
  logic [7:0]            w_flags;
  logic                  w_lost_clr;
  logic [STAT_WIDTH-1:0] w_clear_nxt;
  logic [STAT_WIDTH-1:0] w_mask_nxt;

  assign w_status    = bus.data_status;
  assign w_flags     = w_status[7:0] & w_status[23:16];
  assign w_lost_clr  = bus.cfg_wr & bus.cfg_data[31];
  assign w_clear_nxt = STAT_WIDTH'(bus.cfg_data[15:0]);
  assign w_mask_nxt  = STAT_WIDTH'({8'h00, bus.cfg_data[23:16]});

  // Timers count down from load value; the terminal count of zero marks expiry.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      r_state    <= S_IDLE;
      r_tmr      <= 16'd0;
      r_hold     <= 16'd0;
      r_irq      <= 1'b0;
      r_flags    <= 8'h00;
      r_en_clear <= 1'b0;
      r_clear    <= '0;
      r_mask     <= '0;
      r_retry    <= 2'd0;
      r_lost     <= 1'b0;
    end else begin
      r_en_clear <= bus.cfg_wr;
      if (bus.cfg_wr) begin
        r_clear <= w_clear_nxt;
        r_mask  <= w_mask_nxt;
      end
      if (w_lost_clr) begin
        r_lost <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_tmr   <= TMR_LOAD;
          r_retry <= 2'd0;
          if (!bus.int_req) begin
            r_state <= S_ASSERT;
            r_irq   <= 1'b1;
            r_flags <= w_flags;
          end
        end

        S_ASSERT: begin
          r_tmr <= r_tmr - 16'd1;
          if (bus.irq_ack) begin
            r_irq   <= 1'b0;
            r_state <= S_WAIT_CLEAR;
          end else if (bus.int_req) begin
            r_irq   <= 1'b0;
            r_retry <= 2'd0;
            r_state <= S_IDLE;
          end else if (r_tmr == 16'd0) begin
            r_irq <= 1'b0;
            if (r_retry < RETRY_MAX) begin
              r_retry <= r_retry + 2'd1;
              r_state <= S_REARM;
            end else begin
              // a loss in the same cycle as a host clear of irq_lost still sets it
              r_lost  <= 1'b1;
              r_hold  <= HOLD_LOAD;
              r_state <= S_HOLDOFF;
            end
          end
        end

        S_REARM: begin
          r_irq   <= 1'b1;
          r_flags <= w_flags;
          r_tmr   <= TMR_LOAD;
          r_state <= S_ASSERT;
        end

        S_WAIT_CLEAR: begin
          if (bus.cfg_wr) begin
            r_hold  <= HOLD_LOAD;
            r_state <= S_HOLDOFF;
          end
        end

        S_HOLDOFF: begin
          if (r_hold == 16'd0) begin
            r_retry <= 2'd0;
            r_state <= S_IDLE;
          end else begin
            r_hold <= r_hold - 16'd1;
          end
        end

        default: begin
          r_irq   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.irq       = r_irq;
  assign bus.irq_flags = r_flags;
  assign bus.en_clear  = r_en_clear;
  assign bus.clear     = r_clear;
  assign bus.mask      = r_mask;
  assign bus.retry_cnt = r_retry;
  assign bus.irq_lost  = r_lost;

endmodule

// File: tb/tb_irq_dispatch.sv
// Bench for irq_dispatch: directed vectors, a phase-level reference model compared
// every cycle, plus hand-computed literal expectations.
module tb_irq_dispatch;
  localparam int SIZE_REG   = 32;
  localparam int STAT_WIDTH = 16;
  localparam int TIMEOUT    = 8;
  localparam int MAX_RETRY  = 2;
  localparam int HOLDOFF    = 4;

  logic clk;
  logic rst_a;
  int   checks = 0;
  int   errors = 0;
  bit   en_cmp = 0;
  int   hi;

  irq_dispatch_if #(.SIZE_REG(SIZE_REG), .STAT_WIDTH(STAT_WIDTH)) bus ();

  irq_dispatch #(
    .SIZE_REG(SIZE_REG), .STAT_WIDTH(STAT_WIDTH), .TIMEOUT(TIMEOUT),
    .MAX_RETRY(MAX_RETRY), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk(clk),
    .rst_a(rst_a),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phases of the interrupt life cycle, with the time irq has been
  // high counted upward and the holdoff counted in elapsed cycles.
  typedef enum int {P_IDLE, P_ON, P_GAP, P_WAIT, P_HOLD} phase_t;
  phase_t      m_phase;
  int          m_age, m_hold, m_retry;
  logic        m_irq, m_en_clear, m_lost, m_set_lost;
  logic [7:0]  m_flags;
  logic [15:0] m_clear, m_mask;

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      m_phase = P_IDLE; m_age = 0; m_hold = 0; m_retry = 0;
      m_irq = 0; m_en_clear = 0; m_lost = 0; m_flags = 0; m_clear = 0; m_mask = 0;
    end else begin
      m_set_lost = 0;
      m_en_clear = bus.cfg_wr;
      if (bus.cfg_wr) begin
        m_clear = bus.cfg_data[15:0];
        m_mask  = {8'h00, bus.cfg_data[23:16]};
      end
      case (m_phase)
        P_IDLE: begin
          m_retry = 0;
          if (!bus.int_req) begin
            m_phase = P_ON; m_irq = 1; m_age = 0;
            m_flags = bus.data_status[7:0] & bus.data_status[23:16];
          end
        end
        P_ON: begin
          m_age++;
          if (bus.irq_ack) begin
            m_irq = 0; m_phase = P_WAIT;
          end else if (bus.int_req) begin
            m_irq = 0; m_retry = 0; m_phase = P_IDLE;
          end else if (m_age == TIMEOUT) begin
            m_irq = 0;
            if (m_retry < MAX_RETRY) begin
              m_retry++; m_phase = P_GAP;
            end else begin
              m_set_lost = 1; m_hold = 0; m_phase = P_HOLD;
            end
          end
        end
        P_GAP: begin
          m_irq = 1; m_age = 0; m_phase = P_ON;
          m_flags = bus.data_status[7:0] & bus.data_status[23:16];
        end
        P_WAIT: begin
          if (bus.cfg_wr) begin
            m_hold = 0; m_phase = P_HOLD;
          end
        end
        P_HOLD: begin
          m_hold++;
          if (m_hold == HOLDOFF) begin
            m_retry = 0; m_phase = P_IDLE;
          end
        end
        default: m_phase = P_IDLE;
      endcase
      if (m_set_lost) m_lost = 1;
      else if (bus.cfg_wr && bus.cfg_data[31]) m_lost = 0;
    end
  end

  always @(negedge clk) begin
    if (en_cmp) begin
      chk("cyc_irq",       {31'd0, bus.irq},       {31'd0, m_irq});
      chk("cyc_irq_flags", {24'd0, bus.irq_flags}, {24'd0, m_flags});
      chk("cyc_en_clear",  {31'd0, bus.en_clear},  {31'd0, m_en_clear});
      chk("cyc_clear",     {16'd0, bus.clear},     {16'd0, m_clear});
      chk("cyc_mask",      {16'd0, bus.mask},      {16'd0, m_mask});
      chk("cyc_retry_cnt", {30'd0, bus.retry_cnt}, m_retry);
      chk("cyc_irq_lost",  {31'd0, bus.irq_lost},  {31'd0, m_lost});
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] d);
    bus.cfg_wr = 1'b1; bus.cfg_data = d;
    cyc();
    bus.cfg_wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0;
    bus.int_req = 1'b1; bus.data_status = '0; bus.cfg_wr = 1'b0;
    bus.cfg_data = '0; bus.irq_ack = 1'b0;
    cyc(3);
    chk("rst_irq", bus.irq, 0);
    chk("rst_flags", bus.irq_flags, 0);
    chk("rst_en_clear", bus.en_clear, 0);
    chk("rst_clear", bus.clear, 0);
    chk("rst_mask", bus.mask, 0);
    chk("rst_retry", bus.retry_cnt, 0);
    chk("rst_lost", bus.irq_lost, 0);
    rst_a = 1'b1; en_cmp = 1;
    cyc();

    // basic handshake
    bus.data_status = 32'h0001_0001; bus.int_req = 1'b0;
    cyc();
    chk("basic_irq", bus.irq, 1);
    chk("basic_flags", bus.irq_flags, 8'h01);
    bus.irq_ack = 1'b1; cyc(); bus.irq_ack = 1'b0;
    chk("basic_ack_irq", bus.irq, 0);
    wr(32'h0001_0001);
    chk("basic_en", bus.en_clear, 1);
    chk("basic_clear", bus.clear, 16'h0001);
    chk("basic_mask", bus.mask, 16'h0001);
    cyc();
    chk("basic_en_drop", bus.en_clear, 0);
    bus.int_req = 1'b1; bus.data_status = '0;
    cyc(5);
    chk("basic_idle_irq", bus.irq, 0);

    // retry and loss
    bus.data_status = 32'h00FF_0012; bus.int_req = 1'b0;
    cyc();
    chk("retry_flags", bus.irq_flags, 8'h12);
    for (int r = 0; r < 3; r++) begin
      hi = 0;
      while (bus.irq === 1'b1 && hi < 20) begin
        hi++;
        cyc();
      end
      chk("retry_high_len", hi, TIMEOUT);
      chk("retry_low_irq", bus.irq, 0);
      if (r < 2) begin
        chk("retry_cnt", bus.retry_cnt, r + 1);
        bus.data_status = 32'h00FF_0020 + r;
        cyc();
        chk("rearm_irq", bus.irq, 1);
        chk("rearm_flags", bus.irq_flags, 8'h20 + r);
      end
    end
    chk("lost_set", bus.irq_lost, 1);
    chk("lost_retry", bus.retry_cnt, 2);
    bus.int_req = 1'b1;
    wr(32'h8000_0000);
    chk("lost_clr", bus.irq_lost, 0);
    cyc(6);
    chk("lost_idle_retry", bus.retry_cnt, 0);

    // withdrawal through a clear while asserted
    bus.data_status = 32'h0004_0004; bus.int_req = 1'b0;
    cyc();
    chk("wd_irq", bus.irq, 1);
    chk("wd_flags", bus.irq_flags, 8'h04);
    cyc(2);
    wr(32'h0004_0004);
    chk("wd_still_on", bus.irq, 1);
    cyc();
    bus.int_req = 1'b1; bus.data_status = '0;
    cyc();
    chk("wd_irq_drop", bus.irq, 0);
    chk("wd_retry", bus.retry_cnt, 0);
    cyc(3);

    // ack on the timeout cycle
    bus.data_status = 32'h0001_0001; bus.int_req = 1'b0;
    cyc();
    cyc(TIMEOUT - 1);
    chk("col_to_pre", bus.irq, 1);
    bus.irq_ack = 1'b1; cyc(); bus.irq_ack = 1'b0;
    chk("col_to_irq", bus.irq, 0);
    chk("col_to_retry", bus.retry_cnt, 0);
    cyc();
    chk("col_to_norearm", bus.irq, 0);
    bus.int_req = 1'b1;
    wr(32'h0001_0001);
    cyc(6);

    // ack together with withdrawal, then stale request through holdoff
    bus.int_req = 1'b0;
    cyc(2);
    bus.irq_ack = 1'b1; bus.int_req = 1'b1;
    cyc();
    bus.irq_ack = 1'b0;
    chk("col_wd_irq", bus.irq, 0);
    bus.int_req = 1'b0;
    cyc(3);
    chk("col_wd_waiting", bus.irq, 0);
    wr(32'h0001_0001);
    for (int i = 0; i < HOLDOFF; i++) begin
      cyc();
      chk("hold_quiet", bus.irq, 0);
    end
    cyc();
    chk("hold_rearm", bus.irq, 1);
    bus.irq_ack = 1'b1; cyc(); bus.irq_ack = 1'b0;
    bus.int_req = 1'b1;
    wr(32'h0001_0001);
    cyc(6);

    // back-to-back writes
    bus.cfg_wr = 1'b1; bus.cfg_data = 32'h0012_0034;
    cyc();
    chk("b2b_en1", bus.en_clear, 1);
    chk("b2b_clear1", bus.clear, 16'h0034);
    chk("b2b_mask1", bus.mask, 16'h0012);
    bus.cfg_data = 32'h0056_0078;
    cyc();
    bus.cfg_wr = 1'b0;
    chk("b2b_en2", bus.en_clear, 1);
    chk("b2b_clear2", bus.clear, 16'h0078);
    chk("b2b_mask2", bus.mask, 16'h0056);
    cyc();
    chk("b2b_en_drop", bus.en_clear, 0);
    chk("b2b_clear_held", bus.clear, 16'h0078);

    // async reset mid-assert
    bus.data_status = 32'h0003_0003; bus.int_req = 1'b0;
    cyc();
    cyc(TIMEOUT + 1);
    chk("ar_pre_irq", bus.irq, 1);
    chk("ar_pre_retry", bus.retry_cnt, 1);
    bus.cfg_wr = 1'b1; bus.cfg_data = 32'h0003_0003;
    cyc();
    bus.cfg_wr = 1'b0;
    chk("ar_pre_en", bus.en_clear, 1);
    #2 rst_a = 1'b0;
    #1;
    chk("ar_irq", bus.irq, 0);
    chk("ar_en_clear", bus.en_clear, 0);
    chk("ar_retry", bus.retry_cnt, 0);
    chk("ar_flags", bus.irq_flags, 0);
    chk("ar_clear", bus.clear, 0);
    bus.int_req = 1'b1;
    cyc(2);
    rst_a = 1'b1;
    cyc();
    chk("ar_post_irq", bus.irq, 0);
    bus.int_req = 1'b0;
    cyc();
    chk("ar_idle_trig", bus.irq, 1);
    chk("ar_idle_flags", bus.irq_flags, 8'h03);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
